pool_window_feeder: RTL and testbench
=====================================

POOL_WINDOW_FEEDER -- requirements
Module: pool_window_feeder

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 16, float16 sample width; CLK_NUM_WIDTH, default 8, window-count width; ADDR_WIDTH, default 12, feature-map buffer address width; DIM_WIDTH, default 8, feature-map dimension width.
REQ-002 SHALL have ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a pooling pass.
- fm_width, fm_height  in  DIM_WIDTH  input feature-map size.
- kernel_size  in  4  square window side K.
- stride  in  4  window step S.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at pass end.
- cfg_err  out  1  illegal configuration at start.
- rd_en  out  1  feature-map buffer read strobe.
- rd_addr  out  ADDR_WIDTH  read address.
- rd_data  in  DATA_WIDTH  read data, valid 1 cycle after rd_en.
- cmp_valid  out  1  cmp_data valid for max-pool unit.
- cmp_data  out  DATA_WIDTH  sample to max-pool unit.
- data_num  out  CLK_NUM_WIDTH  samples per window (K*K).
- result_ready  in  1  max-pool result valid.
- max_pool_result  in  DATA_WIDTH  window maximum.
- wr_en  out  1  output-map write strobe.
- wr_addr  out  ADDR_WIDTH  output address.
- wr_data  out  DATA_WIDTH  written maximum.

Function
REQ-003 SHALL latch fm_width, fm_height, kernel_size, stride on accepted start; later input changes ignored until next pass.
REQ-004 SHALL compute OW=(fm_width-K)/S+1, OH=(fm_height-K)/S+1, integer division.
REQ-005 SHALL use FSM states IDLE, READ, WAIT_RES, WRITE, DONE.
REQ-006 IDLE->READ on start when config legal; start while busy SHALL be ignored.
REQ-007 Illegal config (K=0, S=0, K>fm_width, K>fm_height) SHALL pulse cfg_err one cycle, stay IDLE, no done.
REQ-008 READ SHALL assert rd_en for K*K consecutive cycles, row-major within window, rd_addr=(oy*S+ky)*fm_width+(ox*S+kx).
REQ-009 cmp_valid SHALL assert exactly one cycle after each rd_en with cmp_data=rd_data; data_num=K*K held stable for whole window.
REQ-010 After last read SHALL enter WAIT_RES; no reads issued until result_ready.
REQ-011 On result_ready in WAIT_RES SHALL enter WRITE: wr_en one cycle, wr_addr=oy*OW+ox, wr_data=max_pool_result captured.
REQ-012 After WRITE, ox increments; at ox=OW-1 wraps to 0 and oy increments; after last window (oy=OH-1, ox=OW-1) SHALL enter DONE.
REQ-013 DONE SHALL pulse done one cycle, return IDLE; busy high from cycle after start through DONE inclusive.
REQ-014 result_ready outside WAIT_RES SHALL be ignored.
REQ-015 Address arithmetic SHALL be unsigned, truncated to ADDR_WIDTH.

Reset
REQ-016 rst SHALL force IDLE, counters zero; busy, done, cfg_err, rd_en, cmp_valid, wr_en = 0; rd_addr, wr_addr, cmp_data, wr_data, data_num = 0.
REQ-017 rst mid-pass SHALL abort without write/done; next start runs full pass.

Configuration
REQ-018 POOL_FEEDER_TIMEOUT_EN defined: 8-bit watchdog counts WAIT_RES cycles; at 255 without result_ready SHALL pulse output timeout_err (1 bit, reset 0) and go IDLE without done. Undefined: port and counter absent, WAIT_RES waits indefinitely.

Structure
REQ-019 Shared package SHALL hold DATA_WIDTH, CLK_NUM_WIDTH, ADDR_WIDTH, DIM_WIDTH constants and FSM state encoding.
REQ-020 Window index counter (kx, ky, ox, oy with wrap) SHALL be sub-module pool_window_counter.

Verification
REQ-021 4x4 map 0..15, K=2, S=2: windows read {0,1,4,5},{2,3,6,7},{8,9,12,13},{10,11,14,15}; data_num=4; wr_addr 0..3; one done.
REQ-022 5x5, K=3, S=1: OW=OH=3, 9 writes, first window rd_addr 0,1,2,5,6,7,10,11,12, data_num=9.
REQ-023 K=5 on 4x4 map: cfg_err pulse, no rd_en, busy stays 0.
REQ-024 result_ready delayed 20 cycles: no rd_en during wait; wr_data equals max_pool_result (e.g. 16'h4700) at that cycle.
REQ-025 rst asserted during second window READ: all outputs zero next cycle; new start completes all 4 writes.
REQ-026 POOL_FEEDER_TIMEOUT_EN defined, result_ready never asserted: timeout_err pulses 255 cycles into WAIT_RES, done never asserted.

Source files
------------

// File: rtl/pool_window_feeder_pkg.sv
// Shared constants, FSM state encoding and configuration check for the pooling window feeder.
package pool_window_feeder_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int CLK_NUM_WIDTH = 8;
    localparam int ADDR_WIDTH    = 12;
    localparam int DIM_WIDTH     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_RES,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic logic cfg_legal(input int k, input int s, input int w, input int h);
        return (k != 0) && (s != 0) && (k <= w) && (k <= h);
    endfunction

endpackage

// File: rtl/pool_window_counter.sv
// Window index counters: kx/ky walk the K x K window row-major, ox/oy walk the output map.
module pool_window_counter #(
    parameter int DIM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 step_k,
    input  logic                 step_win,
    input  logic [3:0]           k,
    input  logic [DIM_WIDTH-1:0] ow,
    input  logic [DIM_WIDTH-1:0] oh,
    output logic [3:0]           kx,
    output logic [3:0]           ky,
    output logic [DIM_WIDTH-1:0] ox,
    output logic [DIM_WIDTH-1:0] oy,
    output logic                 last_k,
    output logic                 last_win
);

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    logic [3:0]           kx_q, kx_d, ky_q, ky_d;
    logic [DIM_WIDTH-1:0] ox_q, ox_d, oy_q, oy_d;
    logic [3:0]           k_max;
    logic [DIM_WIDTH-1:0] ow_max, oh_max;

    always_comb begin
        k_max    = k - 4'd1;
        ow_max   = ow - DIM_ONE;
        oh_max   = oh - DIM_ONE;
        last_k   = (kx_q == k_max) && (ky_q == k_max);
        last_win = (ox_q == ow_max) && (oy_q == oh_max);
        kx_d     = kx_q;
        ky_d     = ky_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        if (clr) begin
            kx_d = '0;
            ky_d = '0;
            ox_d = '0;
            oy_d = '0;
        end else begin
            if (step_k) begin
                if (kx_q == k_max) begin
                    kx_d = '0;
                    ky_d = (ky_q == k_max) ? 4'd0 : ky_q + 4'd1;
                end else begin
                    kx_d = kx_q + 4'd1;
                end
            end
            if (step_win) begin
                if (ox_q == ow_max) begin
                    ox_d = '0;
                    oy_d = last_win ? '0 : oy_q + DIM_ONE;
                end else begin
                    ox_d = ox_q + DIM_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            kx_q <= '0;
            ky_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            kx_q <= kx_d;
            ky_q <= ky_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

    assign kx = kx_q;
    assign ky = ky_q;
    assign ox = ox_q;
    assign oy = oy_q;

endmodule

// File: rtl/pool_window_feeder.sv
// Streams each K x K pooling window to a max-pool unit and writes back its result.
// Optional WAIT_RES watchdog with timeout_err output: define POOL_FEEDER_TIMEOUT_EN.
module pool_window_feeder #(
    parameter int DATA_WIDTH    = pool_window_feeder_pkg::DATA_WIDTH,
    parameter int CLK_NUM_WIDTH = pool_window_feeder_pkg::CLK_NUM_WIDTH,
    parameter int ADDR_WIDTH    = pool_window_feeder_pkg::ADDR_WIDTH,
    parameter int DIM_WIDTH     = pool_window_feeder_pkg::DIM_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DIM_WIDTH-1:0]     fm_width,
    input  logic [DIM_WIDTH-1:0]     fm_height,
    input  logic [3:0]               kernel_size,
    input  logic [3:0]               stride,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_err,
    output logic                     rd_en,
    output logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     cmp_valid,
    output logic [DATA_WIDTH-1:0]    cmp_data,
    output logic [CLK_NUM_WIDTH-1:0] data_num,
    input  logic                     result_ready,
    input  logic [DATA_WIDTH-1:0]    max_pool_result,
    output logic                     wr_en,
    output logic [ADDR_WIDTH-1:0]    wr_addr,
    output logic [DATA_WIDTH-1:0]    wr_data
`ifdef POOL_FEEDER_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);

    import pool_window_feeder_pkg::*;

    localparam logic [DIM_WIDTH-1:0] DIM_ONE = {{(DIM_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state_q, state_d;
    logic [DIM_WIDTH-1:0]     fmw_q, fmw_d, ow_q, ow_d, oh_q, oh_d;
    logic [3:0]               k_q, k_d, stride_q, stride_d;
    logic [CLK_NUM_WIDTH-1:0] data_num_q, data_num_d;
    logic [DATA_WIDTH-1:0]    res_q, res_d;
    logic                     cmp_valid_q, cmp_valid_d;
    logic                     cfg_err_q, cfg_err_d;
`ifdef POOL_FEEDER_TIMEOUT_EN
    logic [7:0]               wdog_q, wdog_d;
    logic                     timeout_err_q, timeout_err_d;
`endif

    logic                     legal;
    logic [3:0]               stride_safe;
    logic                     cnt_clr, cnt_step_k, cnt_step_win, last_k, last_win;
    logic [3:0]               kx, ky;
    logic [DIM_WIDTH-1:0]     ox, oy;
    logic [ADDR_WIDTH-1:0]    row_a, col_a;

    pool_window_counter #(.DIM_WIDTH(DIM_WIDTH)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .step_k   (cnt_step_k),
        .step_win (cnt_step_win),
        .k        (k_q),
        .ow       (ow_q),
        .oh       (oh_q),
        .kx       (kx),
        .ky       (ky),
        .ox       (ox),
        .oy       (oy),
        .last_k   (last_k),
        .last_win (last_win)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fmw_q       <= '0;
            ow_q        <= '0;
            oh_q        <= '0;
            k_q         <= '0;
            stride_q    <= '0;
            data_num_q  <= '0;
            res_q       <= '0;
            cmp_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
`ifdef POOL_FEEDER_TIMEOUT_EN
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            fmw_q       <= fmw_d;
            ow_q        <= ow_d;
            oh_q        <= oh_d;
            k_q         <= k_d;
            stride_q    <= stride_d;
            data_num_q  <= data_num_d;
            res_q       <= res_d;
            cmp_valid_q <= cmp_valid_d;
            cfg_err_q   <= cfg_err_d;
`ifdef POOL_FEEDER_TIMEOUT_EN
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        fmw_d       = fmw_q;
        ow_d        = ow_q;
        oh_d        = oh_q;
        k_d         = k_q;
        stride_d    = stride_q;
        data_num_d  = data_num_q;
        res_d       = res_q;
        cmp_valid_d = (state_q == ST_READ);
        cfg_err_d   = 1'b0;
        legal       = cfg_legal(int'(kernel_size), int'(stride), int'(fm_width), int'(fm_height));
        stride_safe = (stride == 4'd0) ? 4'd1 : stride;
`ifdef POOL_FEEDER_TIMEOUT_EN
        wdog_d        = (state_q == ST_WAIT_RES) ? wdog_q + 8'd1 : 8'd0;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (legal) begin
                        state_d    = ST_READ;
                        fmw_d      = fm_width;
                        k_d        = kernel_size;
                        stride_d   = stride;
                        ow_d       = (fm_width - DIM_WIDTH'(kernel_size)) / DIM_WIDTH'(stride_safe) + DIM_ONE;
                        oh_d       = (fm_height - DIM_WIDTH'(kernel_size)) / DIM_WIDTH'(stride_safe) + DIM_ONE;
                        data_num_d = CLK_NUM_WIDTH'(kernel_size) * CLK_NUM_WIDTH'(kernel_size);
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (last_k) begin
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (result_ready) begin
                    res_d   = max_pool_result;
                    state_d = ST_WRITE;
                end
`ifdef POOL_FEEDER_TIMEOUT_EN
                else if (wdog_q == 8'd254) begin
                    state_d       = ST_IDLE;
                    timeout_err_d = 1'b1;
                end
`endif
            end
            ST_WRITE: state_d = last_win ? ST_DONE : ST_READ;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Addresses wrap at ADDR_WIDTH because every term is evaluated at that width.
    always_comb begin
        row_a        = ADDR_WIDTH'(oy) * ADDR_WIDTH'(stride_q) + ADDR_WIDTH'(ky);
        col_a        = ADDR_WIDTH'(ox) * ADDR_WIDTH'(stride_q) + ADDR_WIDTH'(kx);
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
        rd_en        = (state_q == ST_READ);
        rd_addr      = rd_en ? row_a * ADDR_WIDTH'(fmw_q) + col_a : '0;
        wr_en        = (state_q == ST_WRITE);
        wr_addr      = wr_en ? ADDR_WIDTH'(oy) * ADDR_WIDTH'(ow_q) + ADDR_WIDTH'(ox) : '0;
        wr_data      = wr_en ? res_q : '0;
        cmp_valid    = cmp_valid_q;
        cmp_data     = cmp_valid_q ? rd_data : '0;
        data_num     = data_num_q;
        cfg_err      = cfg_err_q;
        cnt_clr      = (state_q == ST_IDLE);
        cnt_step_k   = (state_q == ST_READ);
        cnt_step_win = (state_q == ST_WRITE);
    end

`ifdef POOL_FEEDER_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_pool_window_feeder.sv
// Self-checking bench for pool_window_feeder: directed and randomized passes against a window-level model.
module tb_pool_window_feeder;

    localparam int DW = 16;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [7:0]    fm_width, fm_height;
    logic [3:0]    kernel_size, stride;
    logic          busy, done, cfg_err, rd_en, cmp_valid, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] cmp_data, max_pool_result, wr_data;
    logic [7:0]    data_num;
    logic          result_ready;
`ifdef POOL_FEEDER_TIMEOUT_EN
    logic          timeout_err;
`endif

    int            tests = 0;
    int            failed = 0;
    logic [DW-1:0] mem [0:4095];

    pool_window_feeder dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .fm_width        (fm_width),
        .fm_height       (fm_height),
        .kernel_size     (kernel_size),
        .stride          (stride),
        .busy            (busy),
        .done            (done),
        .cfg_err         (cfg_err),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .cmp_valid       (cmp_valid),
        .cmp_data        (cmp_data),
        .data_num        (data_num),
        .result_ready    (result_ready),
        .max_pool_result (max_pool_result),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data)
`ifdef POOL_FEEDER_TIMEOUT_EN
        ,
        .timeout_err     (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    // Feature-map buffer: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        $display("[TB] zero-output check: %s", tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".cfg_err"}, cfg_err, 0);
        check({tag, ".rd_en"}, rd_en, 0);
        check({tag, ".cmp_valid"}, cmp_valid, 0);
        check({tag, ".wr_en"}, wr_en, 0);
        check({tag, ".rd_addr"}, rd_addr, 0);
        check({tag, ".wr_addr"}, wr_addr, 0);
        check({tag, ".cmp_data"}, cmp_data, 0);
        check({tag, ".wr_data"}, wr_data, 0);
        check({tag, ".data_num"}, data_num, 0);
    endtask

    // Runs one pass; abort_at > 0 raises rst on that read (counted from 1) and returns.
    task automatic run_pass(input int fw, input int fh, input int k, input int s,
                            input int wait_cyc, input int abort_at);
        int            ow, oh, reads_win, total_reads, wr_cnt, done_cnt, wait_ctr, cycles;
        int            exp_rd[$];
        logic [DW-1:0] exp_cmp[$];
        logic [DW-1:0] max_val;
        bit            waiting;
        ow = (fw - k) / s + 1;
        oh = (fh - k) / s + 1;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < k; ky++)
                    for (int kx = 0; kx < k; kx++)
                        exp_rd.push_back(((oy * s + ky) * fw + ox * s + kx) % 4096);
        $display("[TB] pass %0dx%0d K=%0d S=%0d wait=%0d: %0d windows", fw, fh, k, s, wait_cyc, ow * oh);
        @(negedge clk);
        fm_width = 8'(fw); fm_height = 8'(fh); kernel_size = 4'(k); stride = 4'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fm_width = 8'($urandom); fm_height = 8'($urandom);
        kernel_size = 4'($urandom); stride = 4'($urandom);
        check("busy_after_start", busy, 1);
        reads_win = 0; total_reads = 0; wr_cnt = 0; done_cnt = 0;
        wait_ctr = 0; cycles = 0; waiting = 0; max_val = '0;
        while (cycles < 20000 && done_cnt == 0) begin
            result_ready = 1'b0;
            max_pool_result = DW'($urandom);
            if (waiting) check("no_rd_while_waiting", rd_en, 0);
            if (cmp_valid) begin
                if (exp_cmp.size() == 0) check("cmp_unexpected", cmp_valid, 0);
                else check("cmp_data", cmp_data, exp_cmp.pop_front());
                check("data_num", data_num, k * k);
            end
            if (rd_en && !waiting) begin
                if (exp_rd.size() == 0) check("rd_unexpected", rd_en, 0);
                else check("rd_addr", rd_addr, exp_rd.pop_front());
                exp_cmp.push_back(mem[rd_addr]);
                reads_win++;
                total_reads++;
                if (abort_at != 0 && total_reads == abort_at) begin
                    rst = 1'b1;
                    return;
                end
            end
            if (wr_en) begin
                $display("[TB] write addr=%0d data=%h", wr_addr, wr_data);
                check("wr_addr", wr_addr, wr_cnt);
                check("wr_data", wr_data, max_val);
                wr_cnt++;
            end
            if (done) begin
                done_cnt++;
                check("busy_in_done", busy, 1);
            end
            if (waiting) begin
                if (wait_ctr == 0) begin
                    max_val = DW'($urandom);
                    max_pool_result = max_val;
                    result_ready = 1'b1;
                    waiting = 0;
                end else begin
                    wait_ctr--;
                end
            end else if (reads_win == k * k) begin
                waiting = 1;
                wait_ctr = wait_cyc;
                reads_win = 0;
            end else if ($urandom_range(0, 3) == 0) begin
                result_ready = 1'b1;   // outside WAIT_RES: must be ignored
            end
            @(negedge clk);
            cycles++;
        end
        result_ready = 1'b0;
        check("done_pulses", done_cnt, 1);
        check("write_count", wr_cnt, ow * oh);
        check("reads_left", exp_rd.size(), 0);
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    task automatic cfg_err_case(input int fw, input int fh, input int k, input int s);
        $display("[TB] illegal config %0dx%0d K=%0d S=%0d", fw, fh, k, s);
        @(negedge clk);
        fm_width = 8'(fw); fm_height = 8'(fh); kernel_size = 4'(k); stride = 4'(s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("cfg_err_pulse", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        check("cfg_err_rd_en", rd_en, 0);
        @(negedge clk);
        check("cfg_err_one_cycle", cfg_err, 0);
        check("cfg_err_no_done", done, 0);
        check("cfg_err_idle", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; result_ready = 1'b0; max_pool_result = '0;
        fm_width = '0; fm_height = '0; kernel_size = '0; stride = '0;
        for (int i = 0; i < 4096; i++) mem[i] = DW'(i);
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        run_pass(4, 4, 2, 2, 0, 0);
        run_pass(5, 5, 3, 1, 2, 0);
        run_pass(4, 4, 2, 2, 20, 0);

        cfg_err_case(4, 4, 5, 1);
        cfg_err_case(4, 4, 0, 1);
        cfg_err_case(4, 4, 2, 0);
        cfg_err_case(3, 6, 4, 1);

        run_pass(4, 4, 2, 2, 1, 5);
        @(negedge clk);
        check_zero("mid_pass_reset");
        rst = 1'b0;
        run_pass(4, 4, 2, 2, 0, 0);

        for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
        for (int n = 0; n < 6; n++) begin
            int fw, fh, k, s;
            fw = $urandom_range(1, 12);
            fh = $urandom_range(1, 12);
            k  = $urandom_range(1, (fw < fh) ? fw : fh);
            s  = $urandom_range(1, 4);
            run_pass(fw, fh, k, s, $urandom_range(0, 5), 0);
        end

`ifdef POOL_FEEDER_TIMEOUT_EN
        begin
            int last_rd, seen;
            last_rd = 0; seen = -1;
            $display("[TB] watchdog pass, result_ready withheld");
            @(negedge clk);
            fm_width = 8'd4; fm_height = 8'd4; kernel_size = 4'd2; stride = 4'd2;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int c = 0; c < 400; c++) begin
                if (rd_en) last_rd = c;
                if (timeout_err && seen < 0) seen = c - last_rd;
                check("timeout_no_done", done, 0);
                @(negedge clk);
            end
            check("timeout_delay", seen, 256);
            check("timeout_idle", busy, 0);
            check("timeout_one_pulse", timeout_err, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
